// File: rtl/fetch_stage.sv
// Instruction fetch stage for a synchronous instruction memory.
// Holds a stalled instruction locally so the memory keeps streaming.
module fetch_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [9:0]  branch_target,
    output logic [9:0]  imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instr_out,
    output logic [9:0]  pc_out,
    output logic        instr_valid
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    logic [9:0]  pc;
    logic [9:0]  req_pc;
    logic        req_valid;
    logic [31:0] hold_instr;
    logic [9:0]  hold_pc;

    assign imem_addr = pc;

    // Fetch control: redirect wins, else advance or park the stalled word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            pc         <= '0;
            req_pc     <= '0;
            req_valid  <= 1'b0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else if (branch_taken) begin
            pc        <= branch_target;
            req_valid <= 1'b0;
            state     <= RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (!stall) begin
                        req_pc    <= pc;
                        req_valid <= 1'b1;
                        pc        <= pc + 10'd1;
                    end else if (req_valid) begin
                        hold_instr <= imem_data;
                        hold_pc    <= req_pc;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state     <= RUN;
                        req_pc    <= pc;
                        req_valid <= 1'b1;
                        pc        <= pc + 10'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Present either the live memory word or the parked one; NOP when empty.
    always_comb begin
        instr_out   = '0;
        pc_out      = '0;
        instr_valid = 1'b0;
        unique case (1'b1)
            (state == HOLD): begin
                instr_out   = hold_instr;
                pc_out      = hold_pc;
                instr_valid = 1'b1;
            end
            (state == RUN && req_valid): begin
                instr_out   = imem_data;
                pc_out      = req_pc;
                instr_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a delivery-order model.
// ROM model: M[k] = 32'hA000_0000 + k.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [9:0]  branch_target;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr_out;
    logic [9:0]  pc_out;
    logic        instr_valid;

    int npass;
    int ntot;
    int nfail;

    // Model: next program-order address owed downstream, and whether
    // a fetch has been issued since the last redirect or reset.
    int  exp_pc;
    bit  primed;

    fetch_stage dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .instr_out(instr_out),
        .pc_out(pc_out),
        .instr_valid(instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM
    always @(posedge clk)
        imem_data <= 32'hA000_0000 + {22'b0, imem_addr};

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        ntot++;
        if (got === exp) begin
            npass++;
        end else begin
            nfail++;
            if (nfail <= 20)
                $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [9:0] e;
        e = 10'(exp_pc);
        chk("valid", {31'b0, instr_valid}, {31'b0, primed});
        chk("imem_addr", {22'b0, imem_addr},
            {22'b0, 10'(exp_pc + (primed ? 1 : 0))});
        if (primed) begin
            chk("pc_out", {22'b0, pc_out}, {22'b0, e});
            chk("instr", instr_out, 32'hA000_0000 + {22'b0, e});
        end else begin
            chk("pc_out_nop", {22'b0, pc_out}, 32'h0);
            chk("instr_nop", instr_out, 32'h0);
        end
    endtask

    task automatic step(input logic s, input logic b, input logic [9:0] t);
        @(negedge clk);
        check_outputs();
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        @(posedge clk);
        if (b) begin
            exp_pc = t;
            primed = 1'b0;
        end else if (!s) begin
            if (primed)
                exp_pc = (exp_pc + 1) % 1024;
            primed = 1'b1;
        end
        #1;
    endtask

    task automatic model_reset();
        exp_pc = 0;
        primed = 1'b0;
    endtask

    initial begin
        int s_pct;
        logic s, b;
        logic [9:0] t;
        npass = 0;
        ntot  = 0;
        nfail = 0;
        model_reset();
        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        #12;
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_addr", {22'b0, imem_addr}, 32'h0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_pc", {22'b0, pc_out}, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Straight-line run from reset
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 10'd0);
        model_reset();

        // Stall while presenting pc 2, then release
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        step(1'b0, 1'b0, 10'd0);
        step(1'b0, 1'b0, 10'd0);
        step(1'b0, 1'b0, 10'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'd0);
        step(1'b0, 1'b0, 10'd0);
        step(1'b0, 1'b0, 10'd0);

        // Branch while stalled
        step(1'b1, 1'b1, 10'h200);
        step(1'b0, 1'b0, 10'd0);
        step(1'b0, 1'b0, 10'd0);

        // Branch near the top of the address space, wrap
        step(1'b0, 1'b1, 10'd1022);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 10'd0);

        // Async reset in HOLD
        step(1'b0, 1'b0, 10'd0);
        step(1'b1, 1'b0, 10'd0);
        step(1'b1, 1'b0, 10'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, instr_valid}, 32'h0);
        chk("arst_addr", {22'b0, imem_addr}, 32'h0);
        chk("arst_instr", instr_out, 32'h0);
        model_reset();
        stall        = 1'b0;
        branch_taken = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 10'd0);

        // Random stall/branch stream
        for (int i = 0; i < 10000; i++) begin
            s_pct = (i / 1000) % 2 == 0 ? 30 : 70;
            s = ($urandom_range(0, 99) < s_pct);
            b = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 3) == 0)
                t = 10'(1020 + $urandom_range(0, 3));
            else
                t = 10'($urandom_range(0, 1023));
            step(s, b, t);
        end
        @(negedge clk);
        check_outputs();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have no parameters; address width is fixed at 10 bits and instruction width at 32 bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port stall, input, 1 bit: downstream not accepting the presented instruction.
REQ-005 The block SHALL have port branch_taken, input, 1 bit: redirect fetch and squash everything in flight.
REQ-006 The block SHALL have port branch_target, input, 10 bits: redirect word address.
REQ-007 The block SHALL have port imem_addr, output, 10 bits: word address to the synchronous instruction memory.
REQ-008 The block SHALL have port imem_data, input, 32 bits: memory output, equal to M[imem_addr] sampled on the previous edge.
REQ-009 The block SHALL have port instr_out, output, 32 bits: instruction presented downstream.
REQ-010 The block SHALL have port pc_out, output, 10 bits: word address of instr_out.
REQ-011 The block SHALL have port instr_valid, output, 1 bit: instr_out/pc_out are meaningful.

Function
REQ-012 Internal state SHALL be: pc[9:0] (next address to request); req_pc[9:0] and req_valid (address requested last edge); hold_instr[31:0] and hold_pc[9:0]; and a state register with states RUN and HOLD.
REQ-013 imem_addr SHALL equal pc combinationally in all states.
REQ-014 In RUN, outputs SHALL be: instr_out = imem_data, pc_out = req_pc, instr_valid = req_valid.
REQ-015 In HOLD, outputs SHALL be: instr_out = hold_instr, pc_out = hold_pc, instr_valid = 1.
REQ-016 When instr_valid = 0, instr_out SHALL be forced to 32'h0 (NOP) and pc_out to 0.
REQ-017 An instruction is accepted on an edge where instr_valid = 1 and stall = 0.
REQ-018 RUN, stall = 0, branch_taken = 0: on the edge, req_pc <= pc, req_valid <= 1, pc <= pc+1; state stays RUN.
REQ-019 RUN, stall = 1, req_valid = 1, branch_taken = 0: on the edge, hold_instr <= imem_data, hold_pc <= req_pc, state <= HOLD; pc unchanged.
REQ-020 RUN, stall = 1, req_valid = 0, branch_taken = 0: all state SHALL hold (no fetch issued).
REQ-021 HOLD, stall = 1, branch_taken = 0: all state SHALL hold.
REQ-022 HOLD, stall = 0, branch_taken = 0: on the edge, state <= RUN, req_pc <= pc, req_valid <= 1, pc <= pc+1.
REQ-023 The HOLD-to-RUN transition SHALL insert zero bubbles, because imem_data already equals M[pc].
REQ-024 branch_taken = 1 SHALL have priority over stall in any state: on the edge, pc <= branch_target, req_valid <= 0, state <= RUN.
REQ-025 After a branch, instr_valid SHALL be 0 for exactly one cycle, then present M[branch_target] with pc_out = branch_target, if no further branch occurs.
REQ-026 pc increment SHALL wrap modulo 1024 (1023 -> 0) with no flag.
REQ-027 Across any stall/branch sequence, every instruction SHALL be presented exactly once, in program order, between branches.

Reset
REQ-028 While rst_n = 0, asynchronously: pc = 0, req_pc = 0, req_valid = 0, hold_instr = 0, hold_pc = 0, state = RUN.
REQ-029 Consequently during reset: imem_addr = 0, instr_valid = 0, instr_out = 0, pc_out = 0.
REQ-030 Reset asserted mid-stall or mid-branch SHALL discard all held and in-flight instructions.
REQ-031 The first edge after rst_n rises SHALL request address 0; after that edge, instr_valid = 1, pc_out = 0, instr_out = M[0].

Verification (memory model: synchronous ROM, M[k] = 32'hA000_0000 + k)
REQ-032 Reset release, stall = 0 for 5 edges -> pc_out 0,1,2,3,4 with instr_out A000_0000..A000_0004, instr_valid = 1 from first edge.
REQ-033 Stall high for 3 edges while presenting pc 2 -> instr_out held at A000_0002 and imem_addr held at 3; on release, next cycle presents pc 3, no bubble, no duplicate.
REQ-034 branch_taken with branch_target = 10'h200 while stall = 1 -> next cycle instr_valid = 0 and instr_out = 0; following cycle pc_out = 200h, instr_out = A000_0200.
REQ-035 Branch to 1022, run 3 edges -> pc_out 1022, 1023, 0 with instr_out A000_03FE, A000_03FF, A000_0000.
REQ-036 rst_n pulled low asynchronously mid-HOLD -> instr_valid = 0 and imem_addr = 0 immediately, without waiting for a clock edge; after release, the REQ-032 sequence repeats.
REQ-037 Random stall/branch stream for 10k cycles -> scoreboard confirms in-order, exactly-once delivery per REQ-027.
